instr_encoder: RTL

Packs field-level instruction descriptions (format, register indices, funct codes, immediate) into 32-bit RV32 instruction words and buffers them in a small FIFO for the fetch/IMEM side. It is the producer end of the instruction word consumed by `decode`. It is used by the self-test program generator and boot loader to build instruction streams in hardware. Immediates are range-checked, and illegal requests are dropped and counted.

---
 rtl/instr_encoder_if.sv | 27 ++
 rtl/instr_encoder.sv | 73 +++++++
 2 files changed

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: request, FIFO output and status bundle between an instruction producer and instr_encoder
interface instr_encoder_if #(parameter int DEPTH = 4);
  logic                     in_valid;
  logic                     in_ready;
  logic [2:0]               fmt;
  logic [2:0]               funct3;
  logic [6:0]               funct7;
  logic [4:0]               rd;
  logic [4:0]               rs1;
  logic [4:0]               rs2;
  logic [31:0]              imm;
  logic                     flush;
  logic                     instr_valid;
  logic                     instr_ready;
  logic [31:0]              instr;
  logic [$clog2(DEPTH):0]   count;
  logic                     err;
  logic [7:0]               err_cnt;
  modport master (
    output in_valid, fmt, funct3, funct7, rd, rs1, rs2, imm, flush, instr_ready,
    input  in_ready, instr_valid, instr, count, err, err_cnt
  );
  modport slave (
    input  in_valid, fmt, funct3, funct7, rd, rs1, rs2, imm, flush, instr_ready,
    output in_ready, instr_valid, instr, count, err, err_cnt
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32 instruction fields into words, range-checks immediates, buffers words in a FIFO
module instr_encoder #(
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  instr_encoder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0]        mem [DEPTH];
  logic [AW-1:0]      wp, rp;
  logic [AW:0]        cnt;
  logic               err_q;
  logic [7:0]         err_cnt_q;
  logic [31:0]        im, word;
  logic signed [31:0] si;
  logic [6:0]         op;
  logic               legal, acc, push, pop;
  assign im = bus.imm;
  assign si = bus.imm;
  always_comb begin
    op = bus.fmt == 3'd0 ? 7'b0110011 :
         bus.fmt == 3'd1 ? 7'b0010011 :
         bus.fmt == 3'd2 ? 7'b0100011 :
         bus.fmt == 3'd3 ? 7'b1100011 :
         bus.fmt == 3'd4 ? 7'b1101111 : 7'b0110111;
    word = bus.fmt == 3'd0 ? {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, op} :
           bus.fmt == 3'd1 ? {im[11:0], bus.rs1, bus.funct3, bus.rd, op} :
           bus.fmt == 3'd2 ? {im[11:5], bus.rs2, bus.rs1, bus.funct3, im[4:0], op} :
           bus.fmt == 3'd3 ? {im[12], im[10:5], bus.rs2, bus.rs1, bus.funct3, im[4:1], im[11], op} :
           bus.fmt == 3'd4 ? {im[20], im[10:1], im[11], im[19:12], bus.rd, op} :
           bus.fmt == 3'd5 ? {im[31:12], bus.rd, op} : 32'd0;
    legal = bus.fmt == 3'd0 ? 1'b1 :
            (bus.fmt == 3'd1 || bus.fmt == 3'd2) ? (si >= -2048 && si <= 2047) :
            bus.fmt == 3'd3 ? (si >= -4096 && si <= 4094 && !im[0]) :
            bus.fmt == 3'd4 ? (si >= -1048576 && si <= 1048574 && !im[0]) :
            bus.fmt == 3'd5 ? (im[11:0] == 12'd0) : 1'b0;
  end
  assign bus.in_ready    = cnt != (AW+1)'(DEPTH);
  assign bus.instr_valid = cnt != '0;
  assign bus.instr       = mem[rp];
  assign bus.count       = cnt;
  assign bus.err         = err_q;
  assign bus.err_cnt     = err_cnt_q;
  assign acc  = bus.in_valid && bus.in_ready;
  assign push = acc && legal;
  assign pop  = bus.instr_valid && bus.instr_ready;
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= word;
  end
  // flush discards same-cycle push/pop but rejections are still counted
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp        <= '0;
      rp        <= '0;
      cnt       <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q <= acc && !legal;
      if (acc && !legal && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      if (bus.flush) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
      end else begin
        if (push) wp <= wp + 1'b1;
        if (pop) rp <= rp + 1'b1;
        cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end
endmodule
